// File: rtl/adc_pulse_pkg.sv
// Shared definitions for the ADC pulse detector: FSM encoding, event field
// widths and the pedestal-subtraction helper.
package adc_pulse_pkg;

    // Event field widths; an event is {peak, width, timestamp}
    localparam int unsigned PeakW  = 16;
    localparam int unsigned WidthW = 8;
    localparam int unsigned TsW    = 32;
    localparam int unsigned EvtW   = PeakW + WidthW + TsW;

    // Pulse FSM state encoding
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAbove   = 2'd1;
    localparam logic [1:0] StHoldoff = 2'd2;

    // Unsigned subtract that clamps at zero instead of wrapping
    function automatic logic [PeakW-1:0] sat_sub(input logic [PeakW-1:0] a,
                                                 input logic [PeakW-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/adc_event_fifo.sv
// First-word-fall-through event FIFO. The head entry is always visible on
// dout; dout reads as zero while empty so the outputs are clean after reset.
module adc_event_fifo #(
    parameter int unsigned WIDTH = 56,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is still accepted when the head leaves this cycle
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents need no reset because empty masks dout
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count disambiguates full/empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/adc_pulse_detector.sv
// Pulse detector behind adc_controller: pedestal subtraction, threshold
// pulse finding with holdoff and width limit, and a FWFT event queue.
module adc_pulse_detector
    import adc_pulse_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned HOLDOFF_SAMPLES = 2,
    parameter int unsigned MAX_WIDTH       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_enable,
    input  logic [15:0] data_in,
    input  logic        is_error,
    input  logic [15:0] baseline,
    input  logic [15:0] threshold,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [15:0] evt_peak,
    output logic [7:0]  evt_width,
    output logic [31:0] evt_timestamp,
    output logic [15:0] drop_count
);

    localparam int unsigned HoldW = (HOLDOFF_SAMPLES > 1) ? $clog2(HOLDOFF_SAMPLES + 1) : 1;
    localparam logic [WidthW-1:0] MaxWidth = WidthW'(MAX_WIDTH);
    localparam logic [HoldW-1:0]  HoldLoad = HoldW'(HOLDOFF_SAMPLES);

    logic              de_q, stb_q, rise;
    logic [PeakW-1:0]  corr_q;
    logic [TsW-1:0]    idx_q, samp_idx_q;
    logic [1:0]        state_q, state_d;
    logic [PeakW-1:0]  peak_q, peak_d;
    logic [WidthW-1:0] width_q, width_d;
    logic [TsW-1:0]    ts_q, ts_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              push, pop, full, empty, above;
    logic [EvtW-1:0]   evt_dout;
    logic [15:0]       drop_q;

    // Only a fresh rising edge of data_enable outside an error state is a sample
    assign rise  = data_enable & ~de_q & ~is_error;
    assign above = (corr_q > threshold);

    // Stage 1: capture the corrected sample and its index, pulse stb
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q       <= 1'b1;
            stb_q      <= 1'b0;
            corr_q     <= '0;
            idx_q      <= '0;
            samp_idx_q <= '0;
        end else begin
            de_q  <= data_enable;
            stb_q <= rise;
            if (rise) begin
                corr_q     <= sat_sub(data_in, baseline);
                samp_idx_q <= idx_q;
                idx_q      <= idx_q + 1'b1;
            end
        end
    end

    // Stage 2: pulse FSM next state and event emission
    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        width_d = width_q;
        ts_d    = ts_q;
        hold_d  = hold_q;
        push    = 1'b0;
        if (is_error) begin
            state_d = StIdle;
        end else if (stb_q) begin
            case (state_q)
                StIdle: begin
                    if (above) begin
                        state_d = StAbove;
                        peak_d  = corr_q;
                        width_d = 8'd1;
                        ts_d    = samp_idx_q;
                    end
                end
                StAbove: begin
                    if (above) begin
                        peak_d  = (corr_q > peak_q) ? corr_q : peak_q;
                        width_d = width_q + 1'b1;
                        push    = (width_d == MaxWidth);
                    end else begin
                        push = 1'b1;
                    end
                    if (push) begin
                        state_d = (HOLDOFF_SAMPLES == 0) ? StIdle : StHoldoff;
                        hold_d  = HoldLoad;
                    end
                end
                StHoldoff: begin
                    if (hold_q <= HoldW'(1)) state_d = StIdle;
                    else                     hold_d  = hold_q - 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            peak_q  <= '0;
            width_q <= '0;
            ts_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            width_q <= width_d;
            ts_q    <= ts_d;
            hold_q  <= hold_d;
        end
    end

    // Count events lost to a full FIFO with no simultaneous pop, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (push && full && !pop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign pop = ~empty & evt_ready;

    adc_event_fifo #(
        .WIDTH(EvtW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .din  ({peak_d, width_d, ts_d}),
        .pop  (pop),
        .full (full),
        .empty(empty),
        .dout (evt_dout)
    );

    assign evt_valid     = ~empty;
    assign evt_peak      = evt_dout[EvtW-1 -: PeakW];
    assign evt_width     = evt_dout[TsW +: WidthW];
    assign evt_timestamp = evt_dout[TsW-1:0];
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_adc_pulse_detector.sv
// Directed bench for adc_pulse_detector with hand-computed expected events.
module tb_adc_pulse_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_enable = 1'b0;
    logic [15:0] data_in = '0;
    logic        is_error = 1'b0;
    logic [15:0] baseline = 16'd100;
    logic [15:0] threshold = 16'd50;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [15:0] evt_peak;
    logic [7:0]  evt_width;
    logic [31:0] evt_timestamp;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_pulse_detector #(
        .FIFO_DEPTH(2),
        .HOLDOFF_SAMPLES(2),
        .MAX_WIDTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_enable  (data_enable),
        .data_in      (data_in),
        .is_error     (is_error),
        .baseline     (baseline),
        .threshold    (threshold),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_peak     (evt_peak),
        .evt_width    (evt_width),
        .evt_timestamp(evt_timestamp),
        .drop_count   (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising clock edge; leaves the same alignment
    task automatic send_sample(input logic [15:0] v);
        data_in     = v;
        data_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1 data_enable = 1'b0;
        repeat (110) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input string tag, input logic [15:0] p,
                                input logic [7:0] w, input logic [31:0] t);
        int waited = 0;
        while (!evt_valid && waited < 50) begin
            @(posedge clk);
            #1 waited++;
        end
        check({tag, "_valid"}, 64'(evt_valid), 64'd1);
        check({tag, "_peak"}, 64'(evt_peak), 64'(p));
        check({tag, "_width"}, 64'(evt_width), 64'(w));
        check({tag, "_ts"}, 64'(evt_timestamp), 64'(t));
        evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
    endtask

    initial begin
        // Reset state, with data_enable already high across reset release
        data_in     = 16'd1000;
        data_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_peak", 64'(evt_peak), 64'd0);
        check("rst_width", 64'(evt_width), 64'd0);
        check("rst_ts", 64'(evt_timestamp), 64'd0);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1 data_enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        send_sample(16'd100);
        check("rst_no_spurious", 64'(evt_valid), 64'd0);

        // Basic pulse with latency check on the terminating sample
        do_reset();
        send_sample(16'd100);
        send_sample(16'd200);
        send_sample(16'd500);
        send_sample(16'd300);
        data_in     = 16'd120;
        data_enable = 1'b1;
        @(posedge clk);
        #1 check("lat_edge1", 64'(evt_valid), 64'd0);
        @(posedge clk);
        #1 check("lat_edge2", 64'(evt_valid), 64'd1);
        repeat (8) @(posedge clk);
        #1 data_enable = 1'b0;
        repeat (110) @(posedge clk);
        #1;
        expect_event("basic", 16'd400, 8'd3, 32'd1);
        check("basic_empty", 64'(evt_valid), 64'd0);

        // Holdoff: samples at index 3 and 4 ignored
        do_reset();
        send_sample(16'd100);
        send_sample(16'd300);
        send_sample(16'd100);
        send_sample(16'd300);
        send_sample(16'd300);
        send_sample(16'd100);
        send_sample(16'd300);
        send_sample(16'd100);
        expect_event("hold1", 16'd200, 8'd1, 32'd1);
        expect_event("hold2", 16'd200, 8'd1, 32'd6);
        check("hold_empty", 64'(evt_valid), 64'd0);

        // Max width forced termination
        do_reset();
        for (int i = 0; i < 7; i++) send_sample(16'd400);
        send_sample(16'd100);
        expect_event("maxw1", 16'd300, 8'd4, 32'd0);
        expect_event("maxw2", 16'd300, 8'd1, 32'd6);

        // Overflow with a two-entry FIFO and no consumer
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_sample(16'(200 + 100 * k));
            send_sample(16'd100);
            send_sample(16'd100);
            send_sample(16'd100);
        end
        check("ovf_valid", 64'(evt_valid), 64'd1);
        check("ovf_head_peak", 64'(evt_peak), 64'd100);
        check("ovf_drop", 64'(drop_count), 64'd2);
        expect_event("ovf1", 16'd100, 8'd1, 32'd0);
        expect_event("ovf2", 16'd200, 8'd1, 32'd4);
        check("ovf_empty", 64'(evt_valid), 64'd0);
        check("ovf_drop_kept", 64'(drop_count), 64'd2);

        // Asynchronous reset between clock edges with an event pending
        send_sample(16'd300);
        send_sample(16'd100);
        check("arst_pre_valid", 64'(evt_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 64'(evt_valid), 64'd0);
        check("arst_drop", 64'(drop_count), 64'd0);
        check("arst_peak", 64'(evt_peak), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Error mid-pulse discards the pulse and freezes the index
        do_reset();
        send_sample(16'd300);
        send_sample(16'd300);
        is_error = 1'b1;
        send_sample(16'd300);
        is_error = 1'b0;
        send_sample(16'd100);
        check("err_no_event", 64'(evt_valid), 64'd0);
        send_sample(16'd300);
        send_sample(16'd100);
        expect_event("err_next", 16'd200, 8'd1, 32'd3);

        // Baseline saturation and level-held data_enable
        do_reset();
        baseline    = 16'd1000;
        data_in     = 16'd500;
        data_enable = 1'b1;
        repeat (200) @(posedge clk);
        #1 data_enable = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("sat_no_event", 64'(evt_valid), 64'd0);
        baseline = 16'd100;
        send_sample(16'd300);
        send_sample(16'd100);
        expect_event("sat_next", 16'd200, 8'd1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_pulse_detector.md
Name: adc_pulse_detector

Overview:
- Sits directly downstream of adc_controller.
- Consumes its 16-bit data_out / data_enable stream, subtracts a programmable baseline and detects pulses that exceed a threshold.
- Packs each pulse into one event: peak amplitude, width in samples, and start-sample timestamp.
- Buffers events in a small FIFO for the readout/host interface, using a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- HOLDOFF_SAMPLES, 2, samples ignored after a pulse ends before a new pulse may start (0 = none).
- MAX_WIDTH, 255, width at which an ongoing pulse is force-terminated; must be at most 255.

Ports:
- clk  in  1  system clock; the single clock.
- reset  in  1  asynchronous, active-low reset.
- data_enable  in  1  from adc_controller; high for many cycles per sample; only its rising edge is used.
- data_in  in  16  from adc_controller data_out; valid whenever data_enable is high.
- is_error  in  1  from adc_controller; controller is in an error state.
- baseline  in  16  quasi-static config; the pedestal subtracted from every sample.
- threshold  in  16  quasi-static config; the corrected sample must be strictly greater than this to count as "above".
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_peak  out  16  head event: maximum corrected amplitude.
- evt_width  out  8  head event: number of above-threshold samples.
- evt_timestamp  out  32  head event: sample index of the first above-threshold sample.
- drop_count  out  16  events lost to a full FIFO; saturates at 0xFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear: FSM goes to IDLE, sample index=0, drop_count=0, FIFO empty.
  - evt_valid=0 and evt_peak/evt_width/evt_timestamp=0.
  - Edge-detect register=1, so a data_enable already high on reset release is not taken as a new sample.
- Stage 1, sample capture:
  - On an edge where data_enable=1 and its previous value was 0, and is_error=0: register corr = (data_in > baseline) ? data_in - baseline : 0 (unsigned, saturates at 0).
  - Register the current sample index into the stage.
  - Pulse stb for one cycle.
  - Increment the sample index on every stb; it wraps 0xFFFFFFFF->0.
- Stage 2, FSM (evaluated only on edges where stb=1):
  - IDLE: if corr>threshold, go to ABOVE with peak=corr, width=1, ts=index.
  - ABOVE, corr>threshold: peak=max(peak,corr), width+1. If the new width equals MAX_WIDTH, emit the event and go to HOLDOFF.
  - ABOVE, corr<=threshold: emit the event (the below-threshold sample is not counted) and go to HOLDOFF.
  - HOLDOFF: the counter loads HOLDOFF_SAMPLES on entry and decrements per stb; at 0 go to IDLE. If HOLDOFF_SAMPLES=0, go to IDLE directly; that sample may not start a pulse.
- Emit: push {peak,width,ts} into the FIFO on the same edge as the FSM transition.
  - Latency: evt_valid rises 2 clk edges after the data_enable rising edge of the terminating sample, when the FIFO was empty.
- FIFO: first-word-fall-through; evt_* show the head entry; pop on an edge where evt_valid and evt_ready.
  - Push while full with a simultaneous pop: accepted.
  - Push while full with no pop: the event is dropped and drop_count increments (saturating).
  - Occupancy never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH, and the count is tracked separately to distinguish full from empty.
  - evt_* hold stable while evt_valid=1 and evt_ready=0.
- is_error=1:
  - No stb is generated; the FSM is forced to IDLE and any partial pulse is discarded without an emit.
  - FIFO contents, sample index and drop_count are retained.
- baseline/threshold changes take effect from the next stb; no glitch protection is required.

Decomposition:
- Package adc_pulse_pkg holds:
  - FSM state encoding (IDLE, ABOVE, HOLDOFF).
  - Event field widths (16/8/32) and the total event width of 56.
  - A helper function for the saturating subtract.
- One sub-module, adc_event_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/dout, active-low async reset.

Test Plan:
- Basic pulse, baseline=100, threshold=50: samples 100,200,500,300,120 (data_enable high 10 cycles, low 110 cycles each) -> one event peak=400, width=3, ts=1; evt_valid rises 2 edges after the 5th sample's rising edge.
- Holdoff, HOLDOFF_SAMPLES=2: samples 100,300,100,300,300,100,300,100 -> first event ts=1. The samples at index 3 and 4 are ignored. Second event ts=6, width=1.
- Max width, MAX_WIDTH=4: seven consecutive samples of 400 -> event width=4, peak=300, ts=0; after a 2-sample holdoff, a new pulse starts at ts=6.
- Overflow, FIFO_DEPTH=2, evt_ready=0: generate 4 events -> evt_valid=1 holding the first event, drop_count=2. Then pulse evt_ready: events 1 and 2 emerge in order, then evt_valid=0.
- Error and reset: is_error=1 mid-pulse -> no event and index frozen. After is_error=0, the next pulse is reported normally. Assert reset=0 asynchronously between clock edges -> evt_valid and drop_count go to 0 immediately.
- Baseline saturation: baseline=1000, data_in=500 -> corr=0, no event; level data_enable held high for 200 cycles yields exactly one sample.
